// File: rtl/rv16_debug_monitor.sv
// rv16_debug_monitor: per-channel change detector queuing {chan, value, ts} events into a FIFO, plus RUN-cycle watchdog.
// Change->ev_valid is 2 cycles; ev_ready low holds the head, a full FIFO coalesces into pending; RV16_DEBUG_MONITOR_TIMESTAMP_EN keeps timestamps.

module rv16_debug_monitor_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_wdat,
  input  logic         i_pop,
  output logic [W-1:0] o_rdat,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wp;
  logic [AW:0]  r_rp;
  logic [W-1:0] r_mem [DEPTH];

  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_empty = (r_wp == r_rp);
  assign o_rdat  = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      // Full is taken from the pointers at the start of the cycle, so a same-cycle pop never frees a slot.
      if (i_push && !o_full) r_wp <= r_wp + 1'b1;
      if (i_pop && !o_empty) r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !o_full) r_mem[r_wp[AW-1:0]] <= i_wdat;
  end
endmodule

module rv16_debug_monitor #(
  parameter int WIDTH      = 16,
  parameter int NUM_CH     = 3,
  parameter int DEPTH      = 16,
  parameter int TS_W       = 16,
  parameter int MAX_CYCLES = 250,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] ch_data,
  input  logic [NUM_CH-1:0]       ch_en,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [CH_W-1:0]         ev_chan,
  output logic [WIDTH-1:0]        ev_data,
  output logic [TS_W-1:0]         ev_ts,
  output logic                    overflow,
  output logic [7:0]              drop_count,
  output logic                    timeout,
  output logic [TS_W-1:0]         cycle_count
);
`ifdef RV16_DEBUG_MONITOR_TIMESTAMP_EN
  localparam int FW = CH_W + WIDTH + TS_W;
`else
  localparam int FW = CH_W + WIDTH;
`endif

  typedef enum logic [1:0] {
    S_PRIME   = 2'd0,
    S_RUN     = 2'd1,
    S_TIMEOUT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_run;

  logic [WIDTH-1:0]  r_shadow [NUM_CH];
  logic [WIDTH-1:0]  r_pval   [NUM_CH];
  logic [NUM_CH-1:0] r_pend;
  logic [TS_W-1:0]   r_cycle;
  logic              r_ovf;
  logic [7:0]        r_drop;

  logic [NUM_CH-1:0] w_change;
  logic [NUM_CH-1:0] w_push_oh;
  logic [NUM_CH-1:0] w_coal;
  logic [4:0]        w_ncoal;
  logic [9:0]        w_drop_sum;
  logic              w_push;
  logic [CH_W-1:0]   w_push_idx;
  logic [WIDTH-1:0]  w_push_val;
  logic [FW-1:0]     w_wdat;
  logic [FW-1:0]     w_rdat;
  logic              w_full;
  logic              w_empty;
`ifdef RV16_DEBUG_MONITOR_TIMESTAMP_EN
  logic [TS_W-1:0]   r_pts [NUM_CH];
  logic [TS_W-1:0]   w_push_ts;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_PRIME;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    timeout     = 1'b0;
    case (r_state)
      S_PRIME: w_state_nxt = S_RUN;
      S_RUN: begin
        w_run = 1'b1;
        if (r_cycle == TS_W'(MAX_CYCLES - 1)) w_state_nxt = S_TIMEOUT;
      end
      S_TIMEOUT: timeout = 1'b1;
      default: w_state_nxt = S_PRIME;
    endcase
  end

  always_comb begin
    w_change   = '0;
    w_push_oh  = '0;
    w_coal     = '0;
    w_ncoal    = '0;
    w_push_idx = '0;
    w_push_val = '0;
`ifdef RV16_DEBUG_MONITOR_TIMESTAMP_EN
    w_push_ts  = '0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      w_change[i] = w_run && ch_en[i] && (ch_data[i*WIDTH +: WIDTH] != r_shadow[i]);
    end
    // Descending scan so the lowest-index pending channel wins.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_push_idx = CH_W'(i);
        w_push_val = r_pval[i];
`ifdef RV16_DEBUG_MONITOR_TIMESTAMP_EN
        w_push_ts  = r_pts[i];
`endif
      end
    end
    w_push = (|r_pend) && !w_full;
    for (int i = 0; i < NUM_CH; i++) begin
      w_push_oh[i] = w_push && (w_push_idx == CH_W'(i));
      w_coal[i]    = w_change[i] && r_pend[i] && !w_push_oh[i];
      w_ncoal      = w_ncoal + {4'd0, w_coal[i]};
    end
    w_drop_sum = {2'b00, r_drop} + {5'd0, w_ncoal};
  end

`ifdef RV16_DEBUG_MONITOR_TIMESTAMP_EN
  assign w_wdat = {w_push_idx, w_push_val, w_push_ts};
`else
  assign w_wdat = {w_push_idx, w_push_val};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend  <= '0;
      r_cycle <= '0;
      r_ovf   <= 1'b0;
      r_drop  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_shadow[i] <= '0;
        r_pval[i]   <= '0;
`ifdef RV16_DEBUG_MONITOR_TIMESTAMP_EN
        r_pts[i]    <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (r_state == S_PRIME) begin
          r_shadow[i] <= ch_data[i*WIDTH +: WIDTH];
        end else if (w_change[i]) begin
          r_shadow[i] <= ch_data[i*WIDTH +: WIDTH];
          r_pend[i]   <= 1'b1;
          r_pval[i]   <= ch_data[i*WIDTH +: WIDTH];
`ifdef RV16_DEBUG_MONITOR_TIMESTAMP_EN
          r_pts[i]    <= r_cycle;
`endif
        end else if (w_push_oh[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
      if (w_run) r_cycle <= r_cycle + 1'b1;
      if (|w_coal) begin
        r_ovf  <= 1'b1;
        r_drop <= (w_drop_sum > 10'd255) ? 8'hFF : w_drop_sum[7:0];
      end
    end
  end

  rv16_debug_monitor_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdat  (w_wdat),
    .i_pop   (ev_ready),
    .o_rdat  (w_rdat),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign ev_valid    = !w_empty;
  assign ev_chan     = w_empty ? '0 : w_rdat[FW-1 -: CH_W];
  assign ev_data     = w_empty ? '0 : w_rdat[FW-CH_W-1 -: WIDTH];
`ifdef RV16_DEBUG_MONITOR_TIMESTAMP_EN
  assign ev_ts       = w_empty ? '0 : w_rdat[TS_W-1:0];
`else
  assign ev_ts       = '0;
`endif
  assign overflow    = r_ovf;
  assign drop_count  = r_drop;
  assign cycle_count = r_cycle;
endmodule

// File: tb/tb_rv16_debug_monitor.sv
// Bench for rv16_debug_monitor: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_rv16_debug_monitor;
  localparam int WIDTH      = 16;
  localparam int NUM_CH     = 3;
  localparam int DEPTH      = 16;
  localparam int TS_W       = 16;
  localparam int MAX_CYCLES = 250;
  localparam int CH_W       = 2;

  localparam int M_PRIME   = 0;
  localparam int M_RUN     = 1;
  localparam int M_TIMEOUT = 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_CH*WIDTH-1:0] ch_data = '0;
  logic [NUM_CH-1:0]       ch_en = '1;
  logic                    ev_ready = 1'b0;
  logic                    ev_valid;
  logic [CH_W-1:0]         ev_chan;
  logic [WIDTH-1:0]        ev_data;
  logic [TS_W-1:0]         ev_ts;
  logic                    overflow;
  logic [7:0]              drop_count;
  logic                    timeout;
  logic [TS_W-1:0]         cycle_count;

  rv16_debug_monitor #(
    .WIDTH      (WIDTH),
    .NUM_CH     (NUM_CH),
    .DEPTH      (DEPTH),
    .TS_W       (TS_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_data     (ch_data),
    .ch_en       (ch_en),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_chan     (ev_chan),
    .ev_data     (ev_data),
    .ev_ts       (ev_ts),
    .overflow    (overflow),
    .drop_count  (drop_count),
    .timeout     (timeout),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: events are plain records in a queue; each channel keeps its last seen value
  // and at most one waiting event.
  typedef struct {
    int chan;
    int data;
    int ts;
  } ev_t;

  ev_t mq[$];
  int  m_mode;
  int  m_cyc;
  bit  m_ovf;
  int  m_drop;
  int  m_shadow [NUM_CH];
  bit  m_pend   [NUM_CH];
  int  m_pval   [NUM_CH];
  int  m_pts    [NUM_CH];

  task automatic model_reset();
    mq.delete();
    m_mode = M_PRIME;
    m_cyc  = 0;
    m_ovf  = 0;
    m_drop = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_shadow[i] = 0;
      m_pend[i]   = 0;
      m_pval[i]   = 0;
      m_pts[i]    = 0;
    end
  endtask

  task automatic model_step();
    bit  was_full;
    int  sel;
    int  d;
    ev_t e;
    if (rst) begin
      model_reset();
      return;
    end
    was_full = (mq.size() == DEPTH);
    if (mq.size() > 0 && ev_ready) e = mq.pop_front();
    sel = -1;
    if (!was_full) begin
      for (int i = 0; i < NUM_CH; i++) if (m_pend[i] && sel < 0) sel = i;
    end
    if (sel >= 0) begin
      e.chan = sel;
      e.data = m_pval[sel];
      e.ts   = m_pts[sel] % (1 << TS_W);
      mq.push_back(e);
      m_pend[sel] = 0;
    end
    if (m_mode == M_PRIME) begin
      for (int i = 0; i < NUM_CH; i++) m_shadow[i] = int'(ch_data[i*WIDTH +: WIDTH]);
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      for (int i = 0; i < NUM_CH; i++) begin
        d = int'(ch_data[i*WIDTH +: WIDTH]);
        if (ch_en[i] && d != m_shadow[i]) begin
          if (m_pend[i]) begin
            m_ovf = 1;
            if (m_drop < 255) m_drop++;
          end
          m_shadow[i] = d;
          m_pend[i]   = 1;
          m_pval[i]   = d;
          m_pts[i]    = m_cyc;
        end
      end
      if (m_cyc == MAX_CYCLES - 1) m_mode = M_TIMEOUT;
      m_cyc++;
    end
  endtask

  task automatic check_outputs();
    int exp_vld;
    int exp_chan;
    int exp_data;
    int exp_ts;
    exp_vld  = (mq.size() != 0) ? 1 : 0;
    exp_chan = 0;
    exp_data = 0;
    exp_ts   = 0;
    if (exp_vld == 1) begin
      exp_chan = mq[0].chan;
      exp_data = mq[0].data;
`ifdef RV16_DEBUG_MONITOR_TIMESTAMP_EN
      exp_ts   = mq[0].ts;
`endif
    end
    check_eq("ev_valid", 32'(ev_valid), exp_vld);
    check_eq("ev_chan", 32'(ev_chan), exp_chan);
    check_eq("ev_data", 32'(ev_data), exp_data);
    check_eq("ev_ts", 32'(ev_ts), exp_ts);
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    check_eq("drop_count", 32'(drop_count), m_drop);
    check_eq("timeout", 32'(timeout), (m_mode == M_TIMEOUT) ? 1 : 0);
    check_eq("cycle_count", 32'(cycle_count), m_cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_ch(input int c, input int v);
    logic [WIDTH-1:0] val;
    val = v[WIDTH-1:0];
    ch_data[c*WIDTH +: WIDTH] = val;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n_pop;
    int last_dat;
    bit ready_hi;
    model_reset();

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check_eq("rst_valid", 32'(ev_valid), 0);
    check_eq("rst_cycle", 32'(cycle_count), 0);
    check_eq("rst_timeout", 32'(timeout), 0);

    // Single change on ch1 at RUN cycle 5
    rst = 1'b0;
    tick();
    repeat (5) tick();
    check_eq("t1_cycle", 32'(cycle_count), 5);
    set_ch(1, 'hAB);
    tick();
    check_eq("t1_not_yet", 32'(ev_valid), 0);
    tick();
    check_eq("t1_valid", 32'(ev_valid), 1);
    check_eq("t1_chan", 32'(ev_chan), 1);
    check_eq("t1_data", 32'(ev_data), 'hAB);
`ifdef RV16_DEBUG_MONITOR_TIMESTAMP_EN
    check_eq("t1_ts", 32'(ev_ts), 5);
`else
    check_eq("t1_ts", 32'(ev_ts), 0);
`endif
    ev_ready = 1'b1;
    tick();

    // All three channels change together
    set_ch(0, 1);
    set_ch(1, 2);
    set_ch(2, 3);
    tick();
    for (int c = 0; c < NUM_CH; c++) begin
      tick();
      check_eq("t2_valid", 32'(ev_valid), 1);
      check_eq("t2_order", 32'(ev_chan), c);
    end
    tick();
    check_eq("t2_empty", 32'(ev_valid), 0);
    check_eq("t2_drop", 32'(drop_count), 0);

    // Fill the FIFO and coalesce on ch2
    ev_ready = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      set_ch(2, 'h100 + k);
      tick();
      tick();
    end
    check_eq("t3_drop", 32'(drop_count), 3);
    check_eq("t3_overflow", 32'(overflow), 1);
    ev_ready = 1'b1;
    n_pop = 0;
    last_dat = 0;
    for (int c = 0; c < 60; c++) begin
      if (ev_valid) begin
        n_pop++;
        last_dat = int'(ev_data);
      end
      tick();
    end
    check_eq("t3_pops", n_pop, 17);
    check_eq("t3_last", last_dat, 'h114);

    // Watchdog
    for (int c = 0; c < 300 && !timeout; c++) tick();
    check_eq("t4_timeout", 32'(timeout), 1);
    check_eq("t4_cycle", 32'(cycle_count), MAX_CYCLES);
    set_ch(0, 'h55);
    repeat (4) tick();
    check_eq("t4_no_event", 32'(ev_valid), 0);
    check_eq("t4_cycle_hold", 32'(cycle_count), MAX_CYCLES);

    // Reset with queued entries and overflow set
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    ev_ready = 1'b0;
    set_ch(0, 'hA0);
    set_ch(1, 'hA1);
    tick();
    set_ch(0, 'hB0);
    set_ch(1, 'hB1);
    repeat (3) tick();
    set_ch(2, 'hC0);
    repeat (2) tick();
    set_ch(2, 'hC1);
    repeat (2) tick();
    check_eq("t5_pre_ovf", 32'(overflow), 1);
    check_eq("t5_pre_valid", 32'(ev_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t5_valid", 32'(ev_valid), 0);
    check_eq("t5_overflow", 32'(overflow), 0);
    check_eq("t5_drop", 32'(drop_count), 0);
    check_eq("t5_cycle", 32'(cycle_count), 0);
    check_eq("t5_data", 32'(ev_data), 0);
    tick();
    repeat (3) tick();
    check_eq("t5_no_event", 32'(ev_valid), 0);
    check_eq("t5_reprime", 32'(cycle_count), 3);

    // Randomized traffic with occasional resets
    for (int run = 0; run < 2; run++) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ready_hi = 1'b1;
      for (int c = 0; c < 400; c++) begin
        if (c % 50 == 0) ready_hi = ~ready_hi;
        if ($urandom_range(0, 2) == 0) set_ch($urandom_range(0, NUM_CH - 1), $urandom_range(0, 3));
        if ($urandom_range(0, 19) == 0) ch_en = NUM_CH'($urandom);
        ev_ready = ready_hi ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
        rst = ($urandom_range(0, 249) == 0);
        tick();
      end
      rst = 1'b0;
      ch_en = '1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
